// File: rtl/addr_range_cmp_pkg.sv
// Shared constants and config-word map for the address-range classifier.
// Word offsets are functions of the rule count so that every file uses the same map.
package addr_range_cmp_pkg;

  localparam logic MODE_OR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

  function automatic int base_word(int k);
    return k;
  endfunction

  function automatic int size_word(int n, int k);
    return n + k;
  endfunction

  function automatic int flags_word(int n, int k);
    return 2 * n + k;
  endfunction

  function automatic int dsm_word(int n);
    return 3 * n;
  endfunction

  function automatic int ctrl_word(int n);
    return 3 * n + 1;
  endfunction

  function automatic int en_word(int n);
    return 3 * n + 2;
  endfunction

  function automatic int miss_word(int n);
    return 3 * n + 3;
  endfunction

  function automatic logic [63:0] apply_be(logic [63:0] old_val, logic [63:0] wdata,
                                           logic [7:0] be);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/addr_range_cmp_rule.sv
// Single [base, base+size) window compare; the limit is one bit wider so the
// window can run to the top of the address space without wrapping.
module addr_range_cmp_rule #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] size_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  match_o
);

  logic [ADDR_WIDTH:0] limit;

  assign limit   = {1'b0, base_i} + {1'b0, size_i};
  assign match_o = en_i && (addr_i >= base_i) && ({1'b0, addr_i} < limit);

endmodule

// File: rtl/addr_range_cmp_pipe.sv
// Two-stage back-pressurable range classifier: S1 holds the match vector and tag,
// S2 holds hit/multi/index/flags. Includes the config regfile and miss counter.
module addr_range_cmp_pipe
  import addr_range_cmp_pkg::*;
#(
  parameter int NUM_RULES      = 32,
  parameter int NUM_RULES_LOG2 = 5,
  parameter int FLAG_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int TAG_WIDTH      = 8,
  parameter int CFG_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CFG_WIDTH-1:0]      cfg_address,
  input  logic                      cfg_write,
  input  logic [63:0]               cfg_writedata,
  input  logic [7:0]                cfg_byteenable,
  input  logic                      cfg_read,
  output logic [63:0]               cfg_readdata,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic [ADDR_WIDTH-1:0]     rx_addr,
  input  logic [TAG_WIDTH-1:0]      rx_tag,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_hit,
  output logic                      tx_multi,
  output logic [NUM_RULES_LOG2-1:0] tx_rule_idx,
  output logic [FLAG_WIDTH-1:0]     tx_flags,
  output logic [TAG_WIDTH-1:0]      tx_tag,
  output logic [63:0]               dsm_base
);

  localparam logic [CFG_WIDTH-1:0] DSM_A  = CFG_WIDTH'(dsm_word(NUM_RULES));
  localparam logic [CFG_WIDTH-1:0] CTRL_A = CFG_WIDTH'(ctrl_word(NUM_RULES));
  localparam logic [CFG_WIDTH-1:0] EN_A   = CFG_WIDTH'(en_word(NUM_RULES));
  localparam logic [CFG_WIDTH-1:0] MISS_A = CFG_WIDTH'(miss_word(NUM_RULES));

  logic [63:0]               base_q  [NUM_RULES];
  logic [63:0]               size_q  [NUM_RULES];
  logic [FLAG_WIDTH-1:0]     flags_q [NUM_RULES];
  logic [63:0]               dsm_q;
  logic                      mode_q;
  logic [NUM_RULES-1:0]      en_q;
  logic [31:0]               miss_q;
  logic [63:0]               rdata_q, rdata_d;

  logic [NUM_RULES-1:0]      match;
  logic                      adv, miss_inc, miss_clr;
  logic                      s1_valid_q;
  logic [NUM_RULES-1:0]      s1_match_q;
  logic [TAG_WIDTH-1:0]      s1_tag_q;
  logic                      s2_valid_q, s2_hit_q, s2_multi_q;
  logic [NUM_RULES_LOG2-1:0] s2_idx_q;
  logic [FLAG_WIDTH-1:0]     s2_flags_q;
  logic [TAG_WIDTH-1:0]      s2_tag_q;
  logic                      hit_d, multi_d;
  logic [NUM_RULES_LOG2-1:0] idx_d;
  logic [FLAG_WIDTH-1:0]     flags_or, flags_prio, flags_d;

  for (genvar k = 0; k < NUM_RULES; k++) begin : g_rule
    addr_range_cmp_rule #(.ADDR_WIDTH(ADDR_WIDTH)) u_rule (
      .base_i  (base_q[k][ADDR_WIDTH-1:0]),
      .size_i  (size_q[k][ADDR_WIDTH-1:0]),
      .en_i    (en_q[k]),
      .addr_i  (rx_addr),
      .match_o (match[k])
    );
  end

  // Window tables are plain storage and deliberately carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_RULES; k++) begin
      if (cfg_write && cfg_address == CFG_WIDTH'(base_word(k)))
        base_q[k] <= apply_be(base_q[k], cfg_writedata, cfg_byteenable);
      if (cfg_write && cfg_address == CFG_WIDTH'(size_word(NUM_RULES, k)))
        size_q[k] <= apply_be(size_q[k], cfg_writedata, cfg_byteenable);
      if (cfg_write && cfg_address == CFG_WIDTH'(flags_word(NUM_RULES, k)))
        flags_q[k] <= FLAG_WIDTH'(apply_be(64'(flags_q[k]), cfg_writedata, cfg_byteenable));
    end
  end

  assign adv      = !s2_valid_q || tx_ready;
  assign miss_inc = s2_valid_q && tx_ready && !s2_hit_q;
  assign miss_clr = cfg_write && cfg_address == MISS_A;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dsm_q  <= '0;
      mode_q <= MODE_OR;
      en_q   <= '0;
      miss_q <= '0;
    end else begin
      if (cfg_write && cfg_address == DSM_A)
        dsm_q <= apply_be(dsm_q, cfg_writedata, cfg_byteenable);
      if (cfg_write && cfg_address == CTRL_A && cfg_byteenable[0])
        mode_q <= cfg_writedata[0];
      if (cfg_write && cfg_address == EN_A)
        en_q <= NUM_RULES'(apply_be(64'(en_q), cfg_writedata, cfg_byteenable));
      // A clear coinciding with a counted miss takes precedence.
      if (miss_clr)
        miss_q <= '0;
      else if (miss_inc && miss_q != '1)
        miss_q <= miss_q + 32'd1;
    end
  end

  always_comb begin
    hit_d      = |s1_match_q;
    multi_d    = |(s1_match_q & (s1_match_q - NUM_RULES'(1)));
    idx_d      = '0;
    flags_or   = '0;
    flags_prio = '0;
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      if (s1_match_q[k]) begin
        idx_d      = NUM_RULES_LOG2'(k);
        flags_prio = flags_q[k];
        flags_or   = flags_or | flags_q[k];
      end
    end
    flags_d = !hit_d ? '0 : (mode_q == MODE_PRIO) ? flags_prio : flags_or;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_multi_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= rx_valid;
      s1_match_q <= match;
      s1_tag_q   <= rx_tag;
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= hit_d;
      s2_multi_q <= multi_d;
      s2_idx_q   <= idx_d;
      s2_flags_q <= flags_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_RULES; k++) begin
      if (cfg_address == CFG_WIDTH'(base_word(k)))             rdata_d = base_q[k];
      if (cfg_address == CFG_WIDTH'(size_word(NUM_RULES, k)))  rdata_d = size_q[k];
      if (cfg_address == CFG_WIDTH'(flags_word(NUM_RULES, k))) rdata_d = 64'(flags_q[k]);
    end
    if (cfg_address == DSM_A)  rdata_d = dsm_q;
    if (cfg_address == CTRL_A) rdata_d = {63'd0, mode_q};
    if (cfg_address == EN_A)   rdata_d = 64'(en_q);
    if (cfg_address == MISS_A) rdata_d = {32'd0, miss_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      rdata_q <= '0;
    else if (cfg_read) rdata_q <= rdata_d;
  end

  assign cfg_readdata = rdata_q;
  assign dsm_base     = dsm_q;
  assign rx_ready     = adv;
  assign tx_valid     = s2_valid_q;
  assign tx_hit       = s2_hit_q;
  assign tx_multi     = s2_multi_q;
  assign tx_rule_idx  = s2_idx_q;
  assign tx_flags     = s2_flags_q;
  assign tx_tag       = s2_tag_q;

endmodule
